// File: rtl/setare_ora_pkg.sv
// rtl/setare_ora_pkg.sv - shared limits, state encodings and wrap arithmetic for the time-setting front end
package setare_ora_pkg;

  localparam logic [4:0] MAX_ORE = 5'd23;
  localparam logic [5:0] MAX_MIN = 6'd59;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SET_ORE = 2'd1;
  localparam logic [1:0] S_SET_MIN = 2'd2;

  typedef struct packed {
    logic mod;
    logic inc;
    logic dec;
  } btn_t;

  // Opposing requests cancel so a simultaneous inc+dec leaves the field untouched.
  function automatic logic [5:0] wrap_step(input logic [5:0] val, input logic [5:0] max,
                                           input logic up, input logic down);
    if (up && !down)
      return (val == max) ? 6'd0 : val + 6'd1;
    else if (down && !up)
      return (val == 6'd0) ? max : val - 6'd1;
    else
      return val;
  endfunction

endpackage

// File: rtl/setare_ora_if.sv
// rtl/setare_ora_if.sv - button, current-time and edit-output bundle of the time-setting front end
interface setare_ora_if;
  logic       btn_mod;
  logic       btn_inc;
  logic       btn_dec;
  logic [4:0] ore;
  logic [5:0] minute;
  logic [4:0] ore_setare;
  logic [5:0] minute_setare;
  logic       semnal_setare;
  logic       camp;
  logic       incarca;

  modport master (
    output btn_mod, btn_inc, btn_dec, ore, minute,
    input  ore_setare, minute_setare, semnal_setare, camp, incarca
  );

  modport slave (
    input  btn_mod, btn_inc, btn_dec, ore, minute,
    output ore_setare, minute_setare, semnal_setare, camp, incarca
  );
endinterface

// File: rtl/setare_ora_debounce_buton.sv
// rtl/setare_ora_debounce_buton.sv - 2-FF synchronizer, stability counter and press pulse for one button
// The debounced level port exists only when AUTO_REPEAT_EN is defined.
module debounce_buton #(
  parameter int DEB_CYCLES = 250_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
`ifdef AUTO_REPEAT_EN
  output logic level,
`endif
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level flips on the DEB_CYCLES-th consecutive sample that disagrees with it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1))
        level_d = sync2_q;
      else
        cnt_d = cnt_q + CW'(1);
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;
`ifdef AUTO_REPEAT_EN
  assign level = level_q;
`endif

endmodule

// File: rtl/setare_ora.sv
// rtl/setare_ora.sv - hours/minutes edit FSM with commit pulse and inactivity timeout
// Optional hold-to-repeat stepping is built when AUTO_REPEAT_EN is defined.
module setare_ora
  import setare_ora_pkg::*;
#(
  parameter int DEB_CYCLES     = 250_000,
  parameter int TIMEOUT_CYCLES = 500_000_000
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY   = 25_000_000,
  parameter int REPEAT_RATE    = 5_000_000
`endif
) (
  input logic         clock,
  input logic         reset,
  setare_ora_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          p_mod, p_inc, p_dec;
  btn_t          press;
  logic          rep_inc, rep_dec;
  logic [1:0]    state_q, state_d;
  logic [4:0]    ore_q, ore_d;
  logic [5:0]    min_q, min_d;
  logic          semnal_q, semnal_d;
  logic          camp_q, camp_d;
  logic          incarca_q, incarca_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          step_up, step_dn, activity, timeout_hit;

`ifdef AUTO_REPEAT_EN
  logic l_mod, l_inc, l_dec;
`endif

  debounce_buton #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mod (
    .clock(clock), .reset(reset), .btn_raw(bus.btn_mod),
`ifdef AUTO_REPEAT_EN
    .level(l_mod),
`endif
    .press(p_mod)
  );

  debounce_buton #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clock(clock), .reset(reset), .btn_raw(bus.btn_inc),
`ifdef AUTO_REPEAT_EN
    .level(l_inc),
`endif
    .press(p_inc)
  );

  debounce_buton #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec (
    .clock(clock), .reset(reset), .btn_raw(bus.btn_dec),
`ifdef AUTO_REPEAT_EN
    .level(l_dec),
`endif
    .press(p_dec)
  );

  assign press = '{mod: p_mod, inc: p_inc, dec: p_dec};

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_first_q, rep_first_d;
  logic          held, rep_step;

  // Holding mod, or both step buttons at once, suppresses repeating.
  assign held = (state_q != S_IDLE) && (l_inc ^ l_dec) && !l_mod;

  always_comb begin
    rep_cnt_d   = '0;
    rep_first_d = 1'b0;
    rep_step    = 1'b0;
    if (held) begin
      if ((!rep_first_q && rep_cnt_q == RW'(REPEAT_DELAY - 1)) ||
          ( rep_first_q && rep_cnt_q == RW'(REPEAT_RATE - 1))) begin
        rep_step    = 1'b1;
        rep_first_d = 1'b1;
      end else begin
        rep_cnt_d   = rep_cnt_q + RW'(1);
        rep_first_d = rep_first_q;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end

  assign rep_inc = rep_step & l_inc;
  assign rep_dec = rep_step & l_dec;
`else
  assign rep_inc = 1'b0;
  assign rep_dec = 1'b0;
`endif

  assign step_up     = press.inc | rep_inc;
  assign step_dn     = press.dec | rep_dec;
  assign activity    = press.mod | step_up | step_dn;
  assign timeout_hit = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    ore_d     = ore_q;
    min_d     = min_q;
    incarca_d = 1'b0;
    to_cnt_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (press.mod) begin
          state_d = S_SET_ORE;
          ore_d   = (bus.ore > MAX_ORE) ? 5'd0 : bus.ore;
          min_d   = (bus.minute > MAX_MIN) ? 6'd0 : bus.minute;
        end
      end
      S_SET_ORE: begin
        if (press.mod)
          state_d = S_SET_MIN;
        else if (activity)
          ore_d = 5'(wrap_step({1'b0, ore_q}, {1'b0, MAX_ORE}, step_up, step_dn));
        else if (timeout_hit)
          state_d = S_IDLE;
        else
          to_cnt_d = to_cnt_q + TW'(1);
      end
      S_SET_MIN: begin
        if (press.mod) begin
          state_d   = S_IDLE;
          incarca_d = 1'b1;
        end else if (activity)
          min_d = wrap_step(min_q, MAX_MIN, step_up, step_dn);
        else if (timeout_hit)
          state_d = S_IDLE;
        else
          to_cnt_d = to_cnt_q + TW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    semnal_d = (state_d != S_IDLE);
    camp_d   = (state_d == S_SET_MIN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ore_q     <= '0;
      min_q     <= '0;
      semnal_q  <= 1'b0;
      camp_q    <= 1'b0;
      incarca_q <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      ore_q     <= ore_d;
      min_q     <= min_d;
      semnal_q  <= semnal_d;
      camp_q    <= camp_d;
      incarca_q <= incarca_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign bus.ore_setare    = ore_q;
  assign bus.minute_setare = min_q;
  assign bus.semnal_setare = semnal_q;
  assign bus.camp          = camp_q;
  assign bus.incarca       = incarca_q;

endmodule

// File: tb/tb_setare_ora.sv
// tb/tb_setare_ora.sv - scoreboard bench: each expected output change is queued, a monitor pops on every change
module tb_setare_ora;

  localparam int DEB = 4;
  localparam int TO  = 200;
  localparam int RD  = 20;
  localparam int RR  = 5;

  typedef struct packed {
    logic [4:0] ore;
    logic [5:0] mn;
    logic       sem;
    logic       camp;
    logic       inc;
  } snap_t;

  logic  clock = 1'b0;
  logic  reset = 1'b1;
  snap_t exp_q[$];
  int    n_checks   = 0;
  int    n_fail     = 0;
  int    inc_cycles = 0;
  bit    mon_en     = 1'b0;
  logic [5:0] rep_exp;

  always #5 clock = ~clock;

  setare_ora_if bus ();

  setare_ora #(
    .DEB_CYCLES(DEB),
    .TIMEOUT_CYCLES(TO)
`ifdef AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR)
`endif
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  function automatic snap_t cur();
    return {bus.ore_setare, bus.minute_setare, bus.semnal_setare, bus.camp, bus.incarca};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_snap(input logic [4:0] o, input logic [5:0] m,
                             input logic s, input logic c, input logic i);
    exp_q.push_back({o, m, s, c, i});
  endtask

  task automatic press(input bit m, input bit i, input bit d, input int hold);
    bus.btn_mod = m;
    bus.btn_inc = i;
    bus.btn_dec = d;
    tick(hold);
    bus.btn_mod = 1'b0;
    bus.btn_inc = 1'b0;
    bus.btn_dec = 1'b0;
    tick(14);
  endtask

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %0d required %0d", name, got, want);
    end
  endtask

  // Monitor: every change of the output tuple must match the next queued expectation.
  initial begin
    snap_t prev, now, e;
    wait (mon_en);
    prev = cur();
    forever begin
      @(negedge clock);
      now = cur();
      if (now.inc === 1'b1) inc_cycles++;
      if (now !== prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change got ore=%0d min=%0d sem=%0b camp=%0b inc=%0b required no change",
                   now.ore, now.mn, now.sem, now.camp, now.inc);
        end else begin
          e = exp_q.pop_front();
          if (now !== e) begin
            n_fail++;
            $display("FAIL scoreboard got ore=%0d min=%0d sem=%0b camp=%0b inc=%0b required ore=%0d min=%0d sem=%0b camp=%0b inc=%0b",
                     now.ore, now.mn, now.sem, now.camp, now.inc, e.ore, e.mn, e.sem, e.camp, e.inc);
          end
        end
        prev = now;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.btn_mod = 1'b0;
    bus.btn_inc = 1'b0;
    bus.btn_dec = 1'b0;
    bus.ore     = 5'd0;
    bus.minute  = 6'd0;
    tick(3);
    reset = 1'b0;
    tick(2);
    check("reset_ore",     bus.ore_setare,    0);
    check("reset_min",     bus.minute_setare, 0);
    check("reset_semnal",  bus.semnal_setare, 0);
    check("reset_camp",    bus.camp,          0);
    check("reset_incarca", bus.incarca,       0);
    mon_en = 1'b1;
    tick(2);

    // Wrap up and commit from 22:58.
    bus.ore = 5'd22; bus.minute = 6'd58;
    expect_snap(22, 58, 1, 0, 0); press(1, 0, 0, 10);
    expect_snap(23, 58, 1, 0, 0); press(0, 1, 0, 10);
    expect_snap(0,  58, 1, 0, 0); press(0, 1, 0, 10);
    expect_snap(0,  58, 1, 1, 0); press(1, 0, 0, 10);
    expect_snap(0,  59, 1, 1, 0); press(0, 1, 0, 10);
    expect_snap(0,  0,  1, 1, 0); press(0, 1, 0, 10);
    expect_snap(0,  0,  0, 0, 1);
    expect_snap(0,  0,  0, 0, 0); press(1, 0, 0, 10);
    check("wrap_commit_drained", exp_q.size(), 0);

    // Out-of-range capture clamps to 0, then decrement wraps.
    bus.ore = 5'd24; bus.minute = 6'd60;
    expect_snap(0,  0,  1, 0, 0); press(1, 0, 0, 10);
    expect_snap(23, 0,  1, 0, 0); press(0, 0, 1, 10);
    expect_snap(23, 0,  1, 1, 0); press(1, 0, 0, 10);
    expect_snap(23, 59, 1, 1, 0); press(0, 0, 1, 10);
    expect_snap(23, 59, 0, 0, 1);
    expect_snap(23, 59, 0, 0, 0); press(1, 0, 0, 10);
    check("dec_wrap_drained", exp_q.size(), 0);

    // Bounce rejection, one clean step, then abandonment by timeout.
    bus.ore = 5'd5; bus.minute = 6'd30;
    expect_snap(5, 30, 1, 0, 0); press(1, 0, 0, 10);
    bus.btn_inc = 1'b1;
    tick(3);
    bus.btn_inc = 1'b0;
    tick(20);
    check("bounce_ore", bus.ore_setare, 5);
    expect_snap(6, 30, 1, 0, 0); press(0, 1, 0, 10);
    tick(150);
    check("timeout_not_early", bus.semnal_setare, 1);
    expect_snap(6, 30, 0, 0, 0);
    tick(100);
    check("timeout_semnal", bus.semnal_setare, 0);
    check("timeout_ore_held", bus.ore_setare, 6);

    // Re-capture, mod beats inc, then reset mid-edit.
    bus.ore = 5'd7; bus.minute = 6'd45;
    expect_snap(7, 45, 1, 0, 0); press(1, 0, 0, 10);
    expect_snap(7, 45, 1, 1, 0); press(1, 1, 0, 10);
    expect_snap(7, 46, 1, 1, 0); press(0, 1, 0, 10);
    expect_snap(0, 0, 0, 0, 0);
    reset = 1'b1;
    tick(2);
    check("midreset_ore",    bus.ore_setare,    0);
    check("midreset_min",    bus.minute_setare, 0);
    check("midreset_semnal", bus.semnal_setare, 0);
    reset = 1'b0;
    tick(10);

    // Held inc in the minutes field.
    bus.ore = 5'd3; bus.minute = 6'd10;
    expect_snap(3, 10, 1, 0, 0); press(1, 0, 0, 10);
    expect_snap(3, 10, 1, 1, 0); press(1, 0, 0, 10);
    expect_snap(3, 11, 1, 1, 0);
`ifdef AUTO_REPEAT_EN
    expect_snap(3, 12, 1, 1, 0);
    expect_snap(3, 13, 1, 1, 0);
    expect_snap(3, 14, 1, 1, 0);
    rep_exp = 6'd14;
`else
    rep_exp = 6'd11;
`endif
    press(0, 1, 0, 32);
    check("hold_min", bus.minute_setare, rep_exp);
    expect_snap(3, rep_exp, 0, 0, 1);
    expect_snap(3, rep_exp, 0, 0, 0); press(1, 0, 0, 10);

    tick(5);
    check("queue_empty", exp_q.size(), 0);
    check("incarca_pulse_cycles", inc_cycles, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
